// File: rtl/mmp_iddmm_arb.sv
// mmp_iddmm_arb: two-channel round-robin arbiter/sequencer in front of one
// mmp_iddmm_sp Montgomery core.
//
// A job is: grant one requester, stream its N x/y operand words out of the
// requester's synchronous buffer into the core's x/y RAMs, pulse task_req,
// then forward each core result word to the granted channel.
//
// Ports
//   clk, rst                    clock, async active-high reset
//   req[1:0]                    per-channel job request (level)
//   gnt[1:0]                    one-hot grant, grant..DONE inclusive
//   op_rd_en/op_rd_addr         operand buffer read (data returns next cycle)
//   op_x0/op_y0, op_x1/op_y1    per-channel operand words
//   m1_cfg                      Montgomery constant, passed to core_wr_m1
//   res_val/res_addr/res_data   per-channel result word stream
//   done[1:0]                   1-cycle job-complete pulse
//   err                         1-cycle pulse on timeout or short result
//   core_*                      write port / start / result of the core
module mmp_iddmm_arb #(
  parameter int K       = 128,
  parameter int N       = 16,
  parameter int ADDR_W  = $clog2(N),
  parameter int TIMEOUT = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  output logic [1:0]        op_rd_en,
  output logic [ADDR_W-1:0] op_rd_addr,
  input  logic [K-1:0]      op_x0,
  input  logic [K-1:0]      op_y0,
  input  logic [K-1:0]      op_x1,
  input  logic [K-1:0]      op_y1,
  input  logic [K-1:0]      m1_cfg,
  output logic [1:0]        res_val,
  output logic [ADDR_W-1:0] res_addr,
  output logic [K-1:0]      res_data,
  output logic [1:0]        done,
  output logic              err,
  output logic [1:0]        core_wr_ena,
  output logic [ADDR_W-1:0] core_wr_addr,
  output logic [K-1:0]      core_wr_x,
  output logic [K-1:0]      core_wr_y,
  output logic [K-1:0]      core_wr_m1,
  output logic              core_task_req,
  input  logic              core_task_grant,
  input  logic [K-1:0]      core_task_res,
  input  logic              core_task_end
);

  // Counters carry one extra bit so they can hold the value N itself.
  localparam int CW = ADDR_W + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] N_C     = CW'(N);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DONE} st_t;

  st_t           state, nstate;
  logic          last;      // last-served channel
  logic          hold;      // holds off a regrant for the first IDLE cycle
  logic [CW-1:0] rc, wc, wc_eff;
  logic [TW-1:0] tc;
  logic [1:0]    pick;
  logic          acc, set_err;

  assign core_wr_m1 = m1_cfg;

  always_comb begin
    nstate        = state;
    pick          = 2'b00;
    op_rd_en      = 2'b00;
    op_rd_addr    = '0;
    core_wr_ena   = 2'b00;
    core_wr_addr  = '0;
    core_wr_x     = '0;
    core_wr_y     = '0;
    core_task_req = 1'b0;
    done          = 2'b00;
    acc           = 1'b0;
    wc_eff        = wc;
    set_err       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!hold && req != 2'b00) begin
          // on contention the channel not served last wins
          pick   = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
          nstate = S_LOAD;
        end
      end
      S_LOAD: begin
        if (rc < N_C) begin
          op_rd_en   = gnt;
          op_rd_addr = ADDR_W'(rc);
        end
        // buffer data lags the read by a cycle, so the write trails rc by one
        if (rc != '0) begin
          core_wr_ena  = 2'b11;
          core_wr_addr = ADDR_W'(rc - CW'(1));
          core_wr_x    = gnt[1] ? op_x1 : op_x0;
          core_wr_y    = gnt[1] ? op_y1 : op_y0;
        end
        if (rc == N_C) nstate = S_ISSUE;
      end
      S_ISSUE: begin
        core_task_req = 1'b1;
        nstate        = S_WAIT;
      end
      S_WAIT: begin
        acc    = core_task_grant && (wc < N_C);
        wc_eff = wc + CW'(acc);
        if (core_task_end) begin
          nstate  = S_DONE;
          set_err = (wc_eff != N_C);
        end else if (tc == TO_LAST) begin
          nstate  = S_IDLE;
          set_err = 1'b1;
        end
      end
      S_DONE: begin
        done   = gnt;
        nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      gnt      <= 2'b00;
      last     <= 1'b1;
      hold     <= 1'b0;
      rc       <= '0;
      wc       <= '0;
      tc       <= '0;
      res_val  <= 2'b00;
      res_addr <= '0;
      res_data <= '0;
      err      <= 1'b0;
    end else begin
      state   <= nstate;
      err     <= set_err;
      res_val <= acc ? gnt : 2'b00;
      if (acc) begin
        res_addr <= ADDR_W'(wc);
        res_data <= core_task_res;
      end
      case (state)
        S_IDLE: begin
          hold <= 1'b0;
          rc   <= '0;
          if (pick != 2'b00) begin
            gnt  <= pick;
            last <= pick[1];
          end
        end
        S_LOAD:  rc <= rc + CW'(1);
        S_ISSUE: begin
          wc <= '0;
          tc <= '0;
        end
        S_WAIT: begin
          wc <= wc_eff;
          tc <= tc + TW'(1);
          if (nstate == S_IDLE) begin   // timeout abort
            gnt  <= 2'b00;
            hold <= 1'b1;
          end
        end
        S_DONE: begin
          gnt  <= 2'b00;
          hold <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmp_iddmm_arb.sv
// Bench for mmp_iddmm_arb: table of jobs plus hand-written timeout and
// reset-mid-LOAD sequences; a behavioural core pushes expected result words
// to a scoreboard queue that is popped as res_val appears.
module tb_mmp_iddmm_arb;
  localparam int K = 128, N = 16, AW = 4, TO = 64;

  logic          clk = 1'b0, rst;
  logic [1:0]    req, gnt, op_rd_en, res_val, done, core_wr_ena;
  logic [AW-1:0] op_rd_addr, res_addr, core_wr_addr;
  logic [K-1:0]  op_x0 = '0, op_y0 = '0, op_x1 = '0, op_y1 = '0, m1_cfg;
  logic [K-1:0]  res_data, core_wr_x, core_wr_y, core_wr_m1, core_task_res;
  logic          err, core_task_req, core_task_grant, core_task_end;

  always #5 clk = ~clk;

  mmp_iddmm_arb #(.K(K), .N(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .op_rd_en(op_rd_en), .op_rd_addr(op_rd_addr),
    .op_x0(op_x0), .op_y0(op_y0), .op_x1(op_x1), .op_y1(op_y1),
    .m1_cfg(m1_cfg), .res_val(res_val), .res_addr(res_addr), .res_data(res_data),
    .done(done), .err(err), .core_wr_ena(core_wr_ena), .core_wr_addr(core_wr_addr),
    .core_wr_x(core_wr_x), .core_wr_y(core_wr_y), .core_wr_m1(core_wr_m1),
    .core_task_req(core_task_req), .core_task_grant(core_task_grant),
    .core_task_res(core_task_res), .core_task_end(core_task_end));

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [K-1:0] bx(input int ch, input int i);
    return (ch == 0) ? K'(i) : K'(32'h100 + i);
  endfunction
  function automatic logic [K-1:0] by(input int ch, input int i);
    return (ch == 0) ? K'(i + 16) : K'(32'h200 + i);
  endfunction

  // requester operand buffers: synchronous read
  always @(posedge clk) begin
    if (op_rd_en[0]) begin op_x0 <= bx(0, op_rd_addr); op_y0 <= by(0, op_rd_addr); end
    if (op_rd_en[1]) begin op_x1 <= bx(1, op_rd_addr); op_y1 <= by(1, op_rd_addr); end
  end

  typedef struct { logic [1:0] val; logic [AW-1:0] addr; logic [K-1:0] data; } sb_t;
  sb_t sbq[$];
  sb_t e;

  // job configuration shared with the core model and monitor
  logic [1:0] exp_gnt = 2'b00;
  int exp_ch = 0, job_tag = 0, core_ngr = 0;
  bit core_end_en = 1'b0, core_ewl = 1'b0;

  // behavioural core: grants start 2 cycles after task_req
  initial begin
    core_task_grant = 1'b0; core_task_end = 1'b0; core_task_res = '0;
    forever begin
      @(posedge clk); #1;
      if (core_task_req && !rst) begin
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < core_ngr; i++) begin
          core_task_grant = 1'b1;
          core_task_res   = K'(32'hA0 + i) + (K'(job_tag) << 16);
          if (core_ewl && i == core_ngr - 1) core_task_end = 1'b1;
          if (i < N) sbq.push_back('{exp_gnt, AW'(i), core_task_res});
          @(posedge clk); #1;
        end
        core_task_grant = 1'b0;
        if (core_end_en && !core_ewl) begin
          core_task_end = 1'b1;
          @(posedge clk); #1;
        end
        core_task_end = 1'b0;
      end
    end
  end

  // monitor
  int cyc = 0, grant_cyc = 0, tr_cyc = 0, end_cyc = 0, err_cyc = 0, done_cyc = 0;
  int wr_cnt = 0, tr_cnt = 0, res_cnt = 0, err_cnt = 0, done_cnt = 0;
  logic [1:0] prev_gnt = 2'b00;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (gnt != 2'b00 && prev_gnt == 2'b00) grant_cyc = cyc;
      if (op_rd_en != 2'b00) chk("op_rd_en", op_rd_en, exp_gnt);
      if (core_wr_ena != 2'b00) begin
        chk("wr_ena", core_wr_ena, 2'b11);
        chk("wr_addr", core_wr_addr, wr_cnt);
        chk("wr_x", core_wr_x, bx(exp_ch, wr_cnt));
        chk("wr_y", core_wr_y, by(exp_ch, wr_cnt));
        wr_cnt++;
      end
      if (core_task_req) begin tr_cnt++; tr_cyc = cyc; end
      if (core_task_end) end_cyc = cyc;
      if (res_val != 2'b00) begin
        if (sbq.size() == 0) chk("res_unexpected", res_val, 2'b00);
        else begin
          e = sbq.pop_front();
          chk("res_val", res_val, e.val);
          chk("res_addr", res_addr, e.addr);
          chk("res_data", res_data, e.data);
        end
        res_cnt++;
      end
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (done != 2'b00) begin done_cnt++; done_cyc = cyc; end
    end
    prev_gnt = gnt;
  end

  typedef struct {
    logic [1:0] req; logic [1:0] gnt; int ngr; bit ewl; bit drop;
    int exp_err; int exp_res; bit gap;
  } job_t;
  job_t jobs[6];

  task automatic wait_gnt(output bit got);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (gnt != 2'b00) begin got = 1'b1; break; end
    end
  endtask

  task automatic run_job(input job_t j, input int tag);
    bit got;
    int err0, done_prev;
    exp_gnt = j.gnt; exp_ch = j.gnt[1] ? 1 : 0; job_tag = tag;
    core_ngr = j.ngr; core_end_en = 1'b1; core_ewl = j.ewl;
    wr_cnt = 0; res_cnt = 0; tr_cnt = 0; err0 = err_cnt; done_prev = done_cyc;
    req = j.req;
    wait_gnt(got);
    chk("grant", gnt, j.gnt);
    if (!got) return;
    if (j.gap) chk("idle_gap", grant_cyc - done_prev, 3);
    if (j.drop) begin repeat (20) @(negedge clk); req = 2'b00; end
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (done != 2'b00) begin got = 1'b1; break; end
    end
    chk("done_seen", got, 1);
    chk("done_val", done, j.gnt);
    chk("err_cnt", err_cnt - err0, j.exp_err);
    chk("wr_cnt", wr_cnt, N);
    chk("task_req_cnt", tr_cnt, 1);
    chk("task_req_lat", tr_cyc - grant_cyc, 17);
    chk("done_lat", done_cyc - end_cyc, 1);
    chk("res_cnt", res_cnt, j.exp_res);
    chk("sb_empty", sbq.size(), 0);
    @(negedge clk); #1;
    chk("gnt_clear", gnt, 2'b00);
    chk("done_pulse", done, 2'b00);
  endtask

  initial begin
    bit got;
    int err0, done0;
    jobs[0] = '{2'b01, 2'b01, 16, 1'b0, 1'b0, 0, 16, 1'b0};  // single job
    jobs[1] = '{2'b11, 2'b10, 16, 1'b0, 1'b0, 0, 16, 1'b0};  // contention
    jobs[2] = '{2'b11, 2'b01, 18, 1'b0, 1'b0, 0, 16, 1'b1};  // extra grants ignored
    jobs[3] = '{2'b11, 2'b10, 16, 1'b1, 1'b0, 0, 16, 1'b1};  // end with last grant
    jobs[4] = '{2'b10, 2'b10, 10, 1'b0, 1'b0, 1, 10, 1'b0};  // short result
    jobs[5] = '{2'b01, 2'b01, 16, 1'b0, 1'b1, 0, 16, 1'b0};  // req dropped in WAIT

    rst = 1'b1; req = 2'b00; m1_cfg = 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978;
    repeat (2) @(posedge clk); #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_rd_en", op_rd_en, 2'b00);
    chk("rst_wr_ena", core_wr_ena, 2'b00);
    chk("rst_task_req", core_task_req, 1'b0);
    chk("rst_res_val", res_val, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_err", err, 1'b0);
    chk("rst_m1", core_wr_m1, 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 6; i++) run_job(jobs[i], i);

    // timeout: core never responds
    exp_gnt = 2'b01; exp_ch = 0; core_ngr = 0; core_end_en = 1'b0; core_ewl = 1'b0;
    wr_cnt = 0; tr_cnt = 0; err0 = err_cnt; done0 = done_cnt;
    req = 2'b01;
    wait_gnt(got);
    chk("to_grant", gnt, 2'b01);
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (err) begin got = 1'b1; break; end
    end
    chk("to_err_seen", got, 1);
    chk("to_err_lat", err_cyc - tr_cyc, 65);
    chk("to_gnt", gnt, 2'b00);
    chk("to_no_done", done_cnt - done0, 0);
    chk("to_err_cnt", err_cnt - err0, 1);
    req = 2'b00;
    run_job('{2'b10, 2'b10, 16, 1'b0, 1'b0, 0, 16, 1'b0}, 6);

    // reset mid-LOAD at rc=5
    exp_gnt = 2'b01; exp_ch = 0; wr_cnt = 0;
    req = 2'b01;
    wait_gnt(got);
    chk("rl_grant", gnt, 2'b01);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (op_rd_en[0] && op_rd_addr == 4'd5) begin got = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk("rl_rc5", got, 1);
    rst = 1'b1; #1;
    chk("rl_gnt", gnt, 2'b00);
    chk("rl_rd_en", op_rd_en, 2'b00);
    chk("rl_wr_ena", core_wr_ena, 2'b00);
    chk("rl_task_req", core_task_req, 1'b0);
    chk("rl_done", done, 2'b00);
    chk("rl_err", err, 1'b0);
    req = 2'b00;
    @(negedge clk); rst = 1'b0;
    run_job('{2'b10, 2'b10, 16, 1'b0, 1'b0, 0, 16, 1'b0}, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
